// File: rtl/sgmii_an_cfg_rx.sv
// rtl/sgmii_an_cfg_rx.sv - 1000BASE-X/SGMII auto-negotiation ordered-set receiver
//
// Parses /C1/, /C2/, /I1/ and /I2/ from the decoded 8b/10b code-group stream,
// extracts the 16-bit config word and runs the ability/ack/idle match counters.
//
// Ports:
//   clock_i          125 MHz code-group clock
//   reset_i          asynchronous active-high reset
//   rx_valid_i       rx_data_i/rx_is_k_i carry one code group this cycle
//   rx_data_i        decoded octet
//   rx_is_k_i        1 = control code group
//   cfg_word_o       last complete config word {hi, lo}
//   cfg_strobe_o     one-cycle pulse per complete /C/ set
//   ability_match_o  MATCH_COUNT equal words (ACK bit ignored)
//   ack_match_o      MATCH_COUNT equal words, all with ACK set
//   idle_match_o     IDLE_COUNT consecutive /I/ sets
//   cfg_zero_o       last config word was all zeros
//   sgmii_link_o     bit 15 of last ability-matched word
//   sgmii_speed_o    bits 11:10 of last ability-matched word
//   sgmii_duplex_o   bit 12 of last ability-matched word
//   err_strobe_o     one-cycle pulse on a framing error
//   err_count_o      saturating framing error count
module sgmii_an_cfg_rx #(
  parameter int MATCH_COUNT = 3,
  parameter int IDLE_COUNT  = 3,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 rx_valid_i,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_is_k_i,
  output logic [15:0]          cfg_word_o,
  output logic                 cfg_strobe_o,
  output logic                 ability_match_o,
  output logic                 ack_match_o,
  output logic                 idle_match_o,
  output logic                 cfg_zero_o,
  output logic                 sgmii_link_o,
  output logic [1:0]           sgmii_speed_o,
  output logic                 sgmii_duplex_o,
  output logic                 err_strobe_o,
  output logic [ERR_CNT_W-1:0] err_count_o
);

  localparam int MCW = $clog2(MATCH_COUNT + 1);
  localparam int ICW = $clog2(IDLE_COUNT + 1);
  localparam logic [MCW-1:0] MATCH_MAX = MCW'(MATCH_COUNT);
  localparam logic [ICW-1:0] IDLE_MAX  = ICW'(IDLE_COUNT);
  localparam logic [15:0]    ACK_MASK  = 16'hBFFF;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    COMMA  = 2'd1,
    CFG_LO = 2'd2,
    CFG_HI = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           lo_q, lo_d;
  logic [15:0]          prev_q, prev_d;
  logic                 prev_valid_q, prev_valid_d;
  logic [MCW-1:0]       ab_cnt_q, ab_cnt_d;
  logic [MCW-1:0]       ack_cnt_q, ack_cnt_d;
  logic [ICW-1:0]       idle_cnt_q, idle_cnt_d;
  logic [15:0]          cfg_word_q, cfg_word_d;
  logic                 cfg_strobe_q, cfg_strobe_d;
  logic                 cfg_zero_q, cfg_zero_d;
  logic                 link_q, link_d;
  logic [1:0]           speed_q, speed_d;
  logic                 duplex_q, duplex_d;
  logic                 err_strobe_q, err_strobe_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic        is_comma, is_c_mark, is_i_mark;
  logic        c_evt, i_evt, err_evt;
  logic [15:0] new_word;

  assign is_comma  = rx_is_k_i && (rx_data_i == 8'hBC);
  assign is_c_mark = !rx_is_k_i && ((rx_data_i == 8'hB5) || (rx_data_i == 8'h42));
  assign is_i_mark = !rx_is_k_i && ((rx_data_i == 8'hC5) || (rx_data_i == 8'h50));
  assign new_word  = {rx_data_i, lo_q};

  always_comb begin
    state_d      = state_q;
    lo_d         = lo_q;
    c_evt        = 1'b0;
    i_evt        = 1'b0;
    err_evt      = 1'b0;
    if (rx_valid_i) begin
      unique case (state_q)
        HUNT: begin
          if (is_comma) state_d = COMMA;
        end
        COMMA: begin
          if (is_c_mark) begin
            state_d = CFG_LO;
          end else begin
            // An erroring K28.5 is consumed here; resync waits for the next one.
            state_d = HUNT;
            if (is_i_mark) i_evt = 1'b1;
            else           err_evt = 1'b1;
          end
        end
        CFG_LO: begin
          if (rx_is_k_i) begin
            state_d = HUNT;
            err_evt = 1'b1;
          end else begin
            lo_d    = rx_data_i;
            state_d = CFG_HI;
          end
        end
        CFG_HI: begin
          state_d = HUNT;
          if (rx_is_k_i) err_evt = 1'b1;
          else           c_evt   = 1'b1;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    ab_cnt_d     = ab_cnt_q;
    ack_cnt_d    = ack_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    cfg_word_d   = cfg_word_q;
    cfg_strobe_d = 1'b0;
    cfg_zero_d   = cfg_zero_q;
    link_d       = link_q;
    speed_d      = speed_q;
    duplex_d     = duplex_q;
    err_strobe_d = 1'b0;
    err_cnt_d    = err_cnt_q;

    if (c_evt) begin
      cfg_word_d   = new_word;
      cfg_strobe_d = 1'b1;
      cfg_zero_d   = (new_word == 16'h0000);
      prev_d       = new_word;
      prev_valid_d = 1'b1;
      idle_cnt_d   = '0;

      // prev_valid_q keeps a first all-zero word from matching the reset value.
      if (prev_valid_q && ((new_word & ACK_MASK) == (prev_q & ACK_MASK)))
        ab_cnt_d = (ab_cnt_q == MATCH_MAX) ? MATCH_MAX : ab_cnt_q + 1'b1;
      else
        ab_cnt_d = MCW'(1);

      if (!new_word[14])
        ack_cnt_d = '0;
      else if (prev_valid_q && (new_word == prev_q))
        ack_cnt_d = (ack_cnt_q == MATCH_MAX) ? MATCH_MAX : ack_cnt_q + 1'b1;
      else
        ack_cnt_d = MCW'(1);

      // SGMII fields capture only on the rising edge of ability_match.
      if ((ab_cnt_d == MATCH_MAX) && (ab_cnt_q != MATCH_MAX)) begin
        link_d   = new_word[15];
        speed_d  = new_word[11:10];
        duplex_d = new_word[12];
      end
    end

    if (i_evt) begin
      idle_cnt_d = (idle_cnt_q == IDLE_MAX) ? IDLE_MAX : idle_cnt_q + 1'b1;
      ab_cnt_d   = '0;
      ack_cnt_d  = '0;
    end

    if (err_evt) begin
      err_strobe_d = 1'b1;
      err_cnt_d    = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;
      ab_cnt_d     = '0;
      ack_cnt_d    = '0;
      idle_cnt_d   = '0;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= HUNT;
      lo_q         <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      ab_cnt_q     <= '0;
      ack_cnt_q    <= '0;
      idle_cnt_q   <= '0;
      cfg_word_q   <= '0;
      cfg_strobe_q <= 1'b0;
      cfg_zero_q   <= 1'b0;
      link_q       <= 1'b0;
      speed_q      <= '0;
      duplex_q     <= 1'b0;
      err_strobe_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      lo_q         <= lo_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      ab_cnt_q     <= ab_cnt_d;
      ack_cnt_q    <= ack_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      cfg_word_q   <= cfg_word_d;
      cfg_strobe_q <= cfg_strobe_d;
      cfg_zero_q   <= cfg_zero_d;
      link_q       <= link_d;
      speed_q      <= speed_d;
      duplex_q     <= duplex_d;
      err_strobe_q <= err_strobe_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign cfg_word_o      = cfg_word_q;
  assign cfg_strobe_o    = cfg_strobe_q;
  assign ability_match_o = (ab_cnt_q == MATCH_MAX);
  assign ack_match_o     = (ack_cnt_q == MATCH_MAX);
  assign idle_match_o    = (idle_cnt_q == IDLE_MAX);
  assign cfg_zero_o      = cfg_zero_q;
  assign sgmii_link_o    = link_q;
  assign sgmii_speed_o   = speed_q;
  assign sgmii_duplex_o  = duplex_q;
  assign err_strobe_o    = err_strobe_q;
  assign err_count_o     = err_cnt_q;

endmodule

// File: tb/tb_sgmii_an_cfg_rx.sv
// tb/tb_sgmii_an_cfg_rx.sv - directed scoreboard bench for sgmii_an_cfg_rx
module tb_sgmii_an_cfg_rx;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_is_k = 1'b0;
  logic [15:0] cfg_word;
  logic        cfg_strobe, ability_match, ack_match, idle_match, cfg_zero;
  logic        sgmii_link, sgmii_duplex, err_strobe;
  logic [1:0]  sgmii_speed;
  logic [7:0]  err_count;

  int total = 0;
  int bad = 0;
  int err_pulses = 0;

  typedef struct {
    logic [15:0] word;
    logic        ab;
    logic        ack;
    logic        idle;
    logic        zero;
    logic        link;
    logic [1:0]  spd;
    logic        dup;
  } exp_t;

  exp_t sb[$];

  sgmii_an_cfg_rx dut (
    .clock_i        (clock),
    .reset_i        (reset),
    .rx_valid_i     (rx_valid),
    .rx_data_i      (rx_data),
    .rx_is_k_i      (rx_is_k),
    .cfg_word_o     (cfg_word),
    .cfg_strobe_o   (cfg_strobe),
    .ability_match_o(ability_match),
    .ack_match_o    (ack_match),
    .idle_match_o   (idle_match),
    .cfg_zero_o     (cfg_zero),
    .sgmii_link_o   (sgmii_link),
    .sgmii_speed_o  (sgmii_speed),
    .sgmii_duplex_o (sgmii_duplex),
    .err_strobe_o   (err_strobe),
    .err_count_o    (err_count)
  );

  always #4 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One code group consumed at the next rising edge; returns 1 time unit after it.
  task automatic cg(input logic k, input logic [7:0] d);
    rx_valid = 1'b1;
    rx_is_k  = k;
    rx_data  = d;
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_c(input logic [7:0] mark, input logic [15:0] w, input int g,
                        input logic ab, input logic ack, input logic zero,
                        input logic link, input logic [1:0] spd, input logic dup);
    exp_t e;
    e.word = w; e.ab = ab; e.ack = ack; e.idle = 1'b0; e.zero = zero;
    e.link = link; e.spd = spd; e.dup = dup;
    sb.push_back(e);
    cg(1'b1, 8'hBC);
    gap(g);
    cg(1'b0, mark);
    gap(g);
    cg(1'b0, w[7:0]);
    gap(g);
    cg(1'b0, w[15:8]);
  endtask

  always @(negedge clock) begin
    if (err_strobe) err_pulses++;
    if (cfg_strobe) begin
      chk("strobe_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("cfg_word", 32'(cfg_word), 32'(e.word));
        chk("ability_match", 32'(ability_match), 32'(e.ab));
        chk("ack_match", 32'(ack_match), 32'(e.ack));
        chk("idle_match", 32'(idle_match), 32'(e.idle));
        chk("cfg_zero", 32'(cfg_zero), 32'(e.zero));
        chk("sgmii_link", 32'(sgmii_link), 32'(e.link));
        chk("sgmii_speed", 32'(sgmii_speed), 32'(e.spd));
        chk("sgmii_duplex", 32'(sgmii_duplex), 32'(e.dup));
      end
    end
  end

  initial begin
    @(posedge clock);
    #1;
    chk("rst_cfg_word", 32'(cfg_word), 32'h0);
    chk("rst_strobes", 32'({cfg_strobe, err_strobe}), 32'h0);
    chk("rst_matches", 32'({ability_match, ack_match, idle_match, cfg_zero}), 32'h0);
    chk("rst_sgmii", 32'({sgmii_link, sgmii_speed, sgmii_duplex}), 32'h0);
    chk("rst_err_count", 32'(err_count), 32'h0);
    reset = 1'b0;
    gap(2);

    // /C1/ 9801 x3: match on third, SGMII fields captured
    send_c(8'hB5, 16'h9801, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    send_c(8'hB5, 16'h9801, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    send_c(8'hB5, 16'h9801, 0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1);
    gap(1);

    // D801 x3: ACK bit ignored for ability, ack_match on third
    send_c(8'hB5, 16'hD801, 0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1);
    send_c(8'h42, 16'hD801, 0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1);
    send_c(8'hB5, 16'hD801, 0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1);
    gap(1);

    // K28.5 K28.5: framing error, resync on following /I2/
    cg(1'b1, 8'hBC);
    cg(1'b1, 8'hBC);
    chk("err_strobe_set", 32'(err_strobe), 32'd1);
    chk("err_count_1", 32'(err_count), 32'd1);
    chk("err_clears_match", 32'({ability_match, ack_match}), 32'h0);
    chk("err_holds_word", 32'(cfg_word), 32'hD801);
    cg(1'b1, 8'hBC);
    chk("err_strobe_pulse", 32'(err_strobe), 32'd0);
    cg(1'b0, 8'h50);
    chk("idle_after_resync", 32'(idle_match), 32'd0);
    chk("err_count_hold", 32'(err_count), 32'd1);

    // re-establish ability match, then /I1/ /I2/ /I1/
    send_c(8'hB5, 16'h9801, 0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1);
    send_c(8'hB5, 16'h9801, 0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1);
    send_c(8'hB5, 16'h9801, 0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1);
    cg(1'b1, 8'hBC); cg(1'b0, 8'hC5);
    chk("idle1_ab_cleared", 32'(ability_match), 32'd0);
    chk("idle1_no_match", 32'(idle_match), 32'd0);
    cg(1'b1, 8'hBC); cg(1'b0, 8'h50);
    chk("idle2_no_match", 32'(idle_match), 32'd0);
    cg(1'b1, 8'hBC); cg(1'b0, 8'hC5);
    chk("idle3_match", 32'(idle_match), 32'd1);
    chk("idle_sgmii_held", 32'({sgmii_link, sgmii_speed, sgmii_duplex}), 32'b1101);
    gap(1);

    // /C2/ 0000 x3: cfg_zero, match clears link
    send_c(8'h42, 16'h0000, 0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1);
    chk("c_clears_idle", 32'(idle_match), 32'd0);
    send_c(8'h42, 16'h0000, 0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1);
    send_c(8'h42, 16'h0000, 0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);

    // rx_valid gaps inside a /C/
    send_c(8'hB5, 16'h9801, 3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    gap(2);

    // reset after CFG_LO: partial set discarded, no strobe
    cg(1'b1, 8'hBC); cg(1'b0, 8'hB5); cg(1'b0, 8'h01);
    reset = 1'b1;
    #1;
    chk("midrst_word", 32'(cfg_word), 32'h0);
    chk("midrst_err_count", 32'(err_count), 32'h0);
    chk("midrst_zero", 32'(cfg_zero), 32'h0);
    gap(1);
    reset = 1'b0;
    cg(1'b0, 8'h98);
    chk("midrst_no_strobe", 32'(cfg_strobe), 32'd0);
    gap(1);

    // first word after reset counts as 1 even though it equals the reset value
    send_c(8'h42, 16'h0000, 0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    send_c(8'h42, 16'h0000, 0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    send_c(8'h42, 16'h0000, 0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    gap(1);

    // err_count saturation
    for (int i = 0; i < 260; i++) begin
      cg(1'b1, 8'hBC);
      cg(1'b1, 8'hBC);
    end
    chk("err_count_sat", 32'(err_count), 32'd255);
    gap(3);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("err_pulses", 32'(err_pulses), 32'd261);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout total=%0d expected_finish", total);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
